alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters using a round-robin policy.

---
 rtl/alu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters. Each operation runs IDLE accept -> EXEC -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [WIDTH-1:0]    resp_result,
  output logic                resp_zero,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0]      alu_a_q, alu_a_d;
  logic [WIDTH-1:0]      alu_b_q, alu_b_d;
  logic [WIDTH-1:0]      resp_result_q, resp_result_d;
  logic                  resp_zero_q, resp_zero_d;

  logic                  grant;
  logic                  any_valid;
  logic                  accept;
  logic                  owner_resp_ready;

  // When both requesters are valid, the one that did not win last time goes.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~req0_valid;
    end
  end

  // Held in reset, nothing is offered to the requesters.
  assign accept     = reset && (state_q == IDLE) && any_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          alu_op_d     = grant ? req1_op : req0_op;
          alu_a_d      = grant ? req1_a  : req0_a;
          alu_b_d      = grant ? req1_b  : req0_b;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_result_d = alu_result;
        resp_zero_d   = alu_zero;
        state_d       = RESP;
      end
      RESP: begin
        if (owner_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) && owner_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with a
//            small reference ALU attached to the alu_* ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Reference ALU: ADD=0, SUB=1, AND=2, OR=3, INC=9, anything else gives 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b1001: alu_result = alu_a + 32'd1;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation from the IDLE accept cycle; resp*_ready must be 1.
  task automatic run_op(input logic own, input logic [31:0] a, input logic [31:0] res,
                        input logic z, input bit scramble);
    #1;
    check("grant_r0", {31'd0, req0_ready}, {31'd0, !own});
    check("grant_r1", {31'd0, req1_ready}, {31'd0, own});
    tick();
    if (scramble) begin
      req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
      req1_a = 32'hCAFE_F00D; req1_b = 32'h8765_4321;
    end
    #1;
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_rdy", {31'd0, req0_ready | req1_ready}, 32'd0);
    check("exec_resp", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    check("exec_alu_a", alu_a, a);
    tick();
    check("resp0_valid", {31'd0, resp0_valid}, {31'd0, !own});
    check("resp1_valid", {31'd0, resp1_valid}, {31'd0, own});
    check("resp_result", resp_result, res);
    check("resp_zero", {31'd0, resp_zero}, {31'd0, z});
    check("resp_rdy", {31'd0, req0_ready | req1_ready}, 32'd0);
    tick();
    check("done_valid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset with both requesters valid
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd3; req1_b = 32'd4;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    tick();
    tick();
    check("rst_r0", {31'd0, req0_ready}, 32'd0);
    check("rst_r1", {31'd0, req1_ready}, 32'd0);
    check("rst_v", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_result", resp_result, 32'd0);

    // Single ADD from req0; operands scrambled after acceptance
    reset = 1'b1;
    req1_valid = 1'b0;
    req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd10;
    run_op(1'b0, 32'd5, 32'd15, 1'b0, 1'b1);

    // Fresh reset so req0 wins the first contended grant
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd7;    req0_b = 32'd7;
    req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 32'hF0; req1_b = 32'h0F;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_op(1'b0, 32'd7, 32'd0, 1'b1, 1'b0);
      else            run_op(1'b1, 32'hF0, 32'hFF, 1'b0, 1'b0);
    end

    // Backpressure on requester 1 while requester 0 waits
    req0_valid = 1'b0;
    req1_op = 4'b0000; req1_a = 32'd1; req1_b = 32'd2;
    resp1_ready = 1'b0;
    #1;
    check("bp_grant1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'hF0; req0_b = 32'h3C;
    resp0_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_v1", {31'd0, resp1_valid}, 32'd1);
      check("bp_v0", {31'd0, resp0_valid}, 32'd0);
      check("bp_result", resp_result, 32'd3);
      check("bp_zero", {31'd0, resp_zero}, 32'd0);
      check("bp_r0", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    resp1_ready = 1'b1;
    #1;
    check("bp_last_v1", {31'd0, resp1_valid}, 32'd1);
    check("bp_last_r0", {31'd0, req0_ready}, 32'd0);
    tick();
    check("bp_done_v1", {31'd0, resp1_valid}, 32'd0);
    check("bp_done_busy", {31'd0, busy}, 32'd0);
    run_op(1'b0, 32'hF0, 32'h30, 1'b0, 1'b0);

    // Reset while the operation is in EXEC
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'd1; req1_b = 32'd1;
    #1;
    check("mid_grant1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_v", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    check("mid_alu_a", alu_a, 32'd0);
    check("mid_result", resp_result, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_novalid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    end
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd2; req0_b = 32'd3;
    run_op(1'b0, 32'd2, 32'd5, 1'b0, 1'b0);

    // INC wraps to zero with B still latched, then an undefined opcode
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b1001; req1_a = 32'hFFFF_FFFF; req1_b = 32'd123;
    run_op(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    check("inc_b_latched", alu_b, 32'd123);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b1111; req0_a = 32'd5; req0_b = 32'd5;
    run_op(1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
    check("undef_op", {28'd0, alu_op}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
